// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcodes, FSM encoding and error codes shared by the UART/ALU sequencer
package uart_alu_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADOP   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;
  typedef enum logic [2:0] {S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_LATCH, S_WAIT_TX} state_t;
  function automatic logic is_valid_op(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction
endpackage

// File: rtl/uart_alu_ctrl_byte_timeout.sv
// byte_timeout: saturating idle counter that flags expiry one clock before it would reach TIMEOUT_CYCLES
module byte_timeout #(
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
  logic [NB_TIMEOUT-1:0] r_count;
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && !i_clear && r_count == LAST;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) r_count <= '0;
    else if (i_clear || o_expired || TIMEOUT_CYCLES == 0) r_count <= '0;
    else if (i_enable && r_count != '1) r_count <= r_count + NB_TIMEOUT'(1);
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: gathers operand A, operand B and opcode from the UART, drives the ALU
// and sends its result back, reporting timeout / bad opcode / overrun faults.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error,
  output logic [1:0]         o_err_code
);
  state_t             r_state, w_next;
  logic [NB_DATA-1:0] r_data_a, r_data_b, r_tx_data;
  logic [NB_OP-1:0]   r_operation;
  logic               r_tx_start, r_error;
  logic [1:0]         r_err_code, w_err_code;
  logic               w_op_ok, w_expired, w_overrun, w_badop, w_error, w_in_wait;

  assign w_op_ok   = (i_rx_data >> NB_OP) == '0 && is_valid_op(i_rx_data[NB_OP-1:0]);
  assign w_in_wait = r_state == S_WAIT_B || r_state == S_WAIT_OP;

  byte_timeout #(.NB_TIMEOUT(NB_TIMEOUT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (i_rx_valid || !w_in_wait),
    .i_enable (w_in_wait),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      r_state     <= S_WAIT_A;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_operation <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state    <= w_next;
      r_error    <= w_error;
      r_err_code <= w_err_code;
      r_tx_start <= r_state == S_LATCH;
      if (r_state == S_LATCH) r_tx_data <= i_alu_result;
      if (i_rx_valid && r_state == S_WAIT_A) r_data_a <= i_rx_data;
      if (i_rx_valid && r_state == S_WAIT_B) r_data_b <= i_rx_data;
      if (i_rx_valid && r_state == S_WAIT_OP && w_op_ok) r_operation <= i_rx_data[NB_OP-1:0];
    end

  // A byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_A:  w_next = i_rx_valid ? S_WAIT_B : S_WAIT_A;
      S_WAIT_B:  w_next = i_rx_valid ? S_WAIT_OP : w_expired ? S_WAIT_A : S_WAIT_B;
      S_WAIT_OP: w_next = i_rx_valid ? (w_op_ok ? S_LATCH : S_WAIT_A) : w_expired ? S_WAIT_A : S_WAIT_OP;
      S_LATCH:   w_next = S_WAIT_TX;
      S_WAIT_TX: w_next = i_tx_done ? S_WAIT_A : S_WAIT_TX;
      default:   w_next = S_WAIT_A;
    endcase
  end

  always_comb begin
    w_overrun  = i_rx_valid && (r_state == S_LATCH || r_state == S_WAIT_TX);
    w_badop    = i_rx_valid && r_state == S_WAIT_OP && !w_op_ok;
    w_error    = w_overrun || w_badop || w_expired;
    w_err_code = w_overrun ? ERR_OVERRUN : w_badop ? ERR_BADOP : w_expired ? ERR_TIMEOUT : r_err_code;
  end

  assign o_data_a    = r_data_a;
  assign o_data_b    = r_data_b;
  assign o_operation = r_operation;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_busy      = r_state != S_WAIT_A;
  assign o_error     = r_error;
  assign o_err_code  = r_err_code;
endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Transaction sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives the ALU inputs.
- Captures the ALU result and launches a single UART transmit.
- Guards the sequence with an inter-byte timeout, opcode validation and overrun detection, reporting each fault as a one-cycle error pulse.

Parameters:
NB_DATA, 8, width of UART bytes, ALU operands and result
NB_OP, 6, ALU opcode width
NB_TIMEOUT, 16, width of inter-byte timeout counter
TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes of one transaction; 0 disables the timeout

Ports:
i_clock  in  1  system clock (50 MHz)
i_reset  in  1  asynchronous reset, active-low
i_rx_data  in  NB_DATA  byte from UART receiver
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_alu_result  in  NB_DATA  combinational ALU result
i_tx_done  in  1  one-cycle strobe, transmitter finished the byte
o_data_a  out  NB_DATA  ALU operand A (signed)
o_data_b  out  NB_DATA  ALU operand B (signed)
o_operation  out  NB_OP  ALU opcode
o_tx_data  out  NB_DATA  byte to transmit
o_tx_start  out  1  one-cycle transmit request
o_busy  out  1  high in every state except WAIT_A
o_error  out  1  one-cycle error strobe
o_err_code  out  2  01 timeout, 10 bad opcode, 11 overrun; held until the next error

Behaviour:
- Reset (i_reset low, asynchronous):
  - state WAIT_A, timeout counter 0;
  - o_data_a, o_data_b, o_operation, o_tx_data, o_err_code all 0;
  - o_tx_start, o_error, o_busy all 0.
- All outputs are registered. o_busy is decoded from the state register.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, LATCH, WAIT_TX.
- WAIT_A: on i_rx_valid, o_data_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_valid, o_data_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_valid, check the opcode byte.
  - Valid means upper NB_DATA-NB_OP bits are 0 and the low bits are one of: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
  - Valid: o_operation <= low NB_OP bits, go to LATCH.
  - Invalid: o_error pulse, o_err_code=10, o_operation unchanged, go to WAIT_A.
- LATCH: exactly one cycle.
  - Lets the ALU settle on the new o_operation.
  - At the exiting edge: o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
- WAIT_TX:
  - o_tx_start returns to 0 after one cycle.
  - On i_tx_done sampled high, go to WAIT_A.
  - i_tx_done in any other state is ignored.
- Latency: opcode strobe at edge N -> o_tx_start high for the cycle after edge N+1. i_tx_done is honoured from edge N+2 onward.
- Overrun: i_rx_valid in LATCH or WAIT_TX -> byte dropped, o_error pulse, o_err_code=11, state unchanged, transmission unaffected.
- Timeout (WAIT_B and WAIT_OP only):
  - counter clears on every accepted byte and increments each cycle without i_rx_valid;
  - on reaching TIMEOUT_CYCLES: o_error pulse, o_err_code=01, go to WAIT_A, counter cleared;
  - a byte strobe in the same cycle as expiry wins, so the byte is accepted and no error is raised;
  - counter saturates, never wraps; inactive (held at 0) when TIMEOUT_CYCLES=0.
- Operands and opcode keep their last values between transactions; the ALU output stays stable for observation.
- Reset asserted mid-transaction: immediate return to the reset state; a pending o_tx_start is cancelled.

Decomposition:
- Package uart_alu_pkg holds:
  - opcode localparams (OP_ADD ... OP_SRL);
  - FSM state encoding;
  - error code constants ERR_TIMEOUT, ERR_BADOP, ERR_OVERRUN;
  - function is_valid_op().
- One sub-module, byte_timeout: clear/enable inputs, expired output, parameterised by NB_TIMEOUT and TIMEOUT_CYCLES.
- The FSM and registers stay in uart_alu_ctrl.

Test Plan:
- Bytes 15, 1, 32 (ADD), 1000 ns apart, ALU attached -> o_data_a=15, o_data_b=1, o_operation=100000, one o_tx_start with o_tx_data=16. i_tx_done returns the FSM to WAIT_A with o_busy=0.
- Bytes 42, 3, 34 (SUB) -> o_tx_data=39. Then bytes 0xF0, 4, 3 (SRA) -> o_tx_data=0xFF. Each transaction produces exactly one o_tx_start.
- Bytes 5, 6, 0x3F -> o_error pulse, o_err_code=10, no o_tx_start, FSM in WAIT_A. Next bytes 2, 2, 32 -> o_tx_data=4.
- TIMEOUT_CYCLES=100, byte 7 then silence -> o_error pulse with o_err_code=01 exactly 100 cycles after the strobe. Byte strobe on cycle 100 instead -> accepted, no error.
- Extra byte sent while in WAIT_TX (i_tx_done held low) -> o_err_code=11, o_tx_data unchanged. The later i_tx_done returns the FSM to WAIT_A.
- i_reset low for 2 cycles between operand B and opcode -> all outputs 0, FSM in WAIT_A. The following opcode byte is treated as operand A.
